// File: rtl/fht_frame_loader.sv
// fht_frame_loader: streams ADC samples into the 4-bank FHT RAM, ping-pongs two frame buffers and issues FHT starts
module fht_frame_loader #(
    parameter int N = 1024,
    parameter int BANKS = 4,
    parameter int D_BIT = 16,
    localparam int A_BIT = $clog2(N / BANKS)
) (
    input  logic               iCLK,
    input  logic               iRESET,
    input  logic               iARM,
    input  logic               iCONT,
    input  logic               iVALID,
    input  logic [D_BIT-2:0]   iDATA,
    output logic               oREADY,
    output logic [BANKS-1:0]   oWE,
    output logic [A_BIT-1:0]   oADDR,
    output logic [D_BIT-1:0]   oDATA,
    output logic               oBUF,
    output logic               oSTART,
    output logic               oSTART_BUF,
    input  logic               iFHT_DONE,
    output logic [1:0]         oBUSY,
    output logic               oOVF
);
    localparam int LN = $clog2(N);
    localparam int LB = $clog2(BANKS);

    typedef enum logic {IDLE, FILL} state_t;

    state_t             state_q, state_d;
    logic [LN-1:0]      cnt_q, cnt_d;
    logic               wr_buf_q, wr_buf_d;
    logic [1:0]         busy_q, busy_d;
    logic               fht_active_q, fht_active_d;
    logic               fht_buf_q, fht_buf_d;
    logic               q0_q, q0_d, q1_q, q1_d;
    logic [1:0]         q_n_q, q_n_d;
    logic [BANKS-1:0]   we_q, we_d;
    logic [A_BIT-1:0]   addr_q, addr_d;
    logic [D_BIT-1:0]   data_q, data_d;
    logic               wbuf_q, wbuf_d;
    logic               start_q, start_d;
    logic               start_buf_q, start_buf_d;
    logic               ovf_q, ovf_d;
    logic               acc, last, pop, done;
    logic [LB-1:0]      top, bank;

    assign oREADY     = (state_q == FILL) && !busy_q[wr_buf_q];
    assign oWE        = we_q;
    assign oADDR      = addr_q;
    assign oDATA      = data_q;
    assign oBUF       = wbuf_q;
    assign oSTART     = start_q;
    assign oSTART_BUF = start_buf_q;
    assign oBUSY      = busy_q;
    assign oOVF       = ovf_q;

    // Next-state logic: fill counter, buffer ownership, start queue and registered write/start outputs
    always_comb begin
        acc  = iVALID && oREADY;
        last = acc && (cnt_q == LN'(N - 1));
        pop  = !fht_active_q && (q_n_q != 2'd0);
        done = iFHT_DONE && fht_active_q;
        top  = cnt_q[LN-1 -: LB];
        bank = '0;
        for (int i = 0; i < LB; i++) bank[i] = top[LB-1-i];
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_buf_d = wr_buf_q;
        busy_d   = busy_q;
        if (state_q == IDLE && iARM) begin
            state_d = FILL;
            cnt_d   = '0;
        end
        if (acc) cnt_d = last ? '0 : cnt_q + 1'b1;
        if (last) begin
            busy_d[wr_buf_q] = 1'b1;
            wr_buf_d         = !wr_buf_q;
            state_d          = iCONT ? FILL : IDLE;
        end
        if (done) busy_d[fht_buf_q] = 1'b0;
        // Two-entry frame-order queue: pop the oldest, then append the just-completed buffer
        q0_d  = pop ? q1_q : q0_q;
        q1_d  = q1_q;
        q_n_d = q_n_q - {1'b0, pop};
        if (last) begin
            if (q_n_d == 2'd0) q0_d = wr_buf_q;
            else q1_d = wr_buf_q;
            q_n_d = q_n_d + 2'd1;
        end
        fht_active_d = pop ? 1'b1 : done ? 1'b0 : fht_active_q;
        fht_buf_d    = pop ? q0_q : fht_buf_q;
        start_d      = pop;
        start_buf_d  = pop ? q0_q : start_buf_q;
        we_d         = acc ? (BANKS'(1) << bank) : '0;
        addr_d       = acc ? cnt_q[A_BIT-1:0] : addr_q;
        data_d       = acc ? {iDATA[D_BIT-2], iDATA} : data_q;
        wbuf_d       = acc ? wr_buf_q : wbuf_q;
        ovf_d        = (state_q == FILL && iVALID && !oREADY) ? 1'b1 : iARM ? 1'b0 : ovf_q;
    end

    // State and output registers; reset discards any partial frame and queued starts
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wr_buf_q     <= 1'b0;
            busy_q       <= '0;
            fht_active_q <= 1'b0;
            fht_buf_q    <= 1'b0;
            q0_q         <= 1'b0;
            q1_q         <= 1'b0;
            q_n_q        <= '0;
            we_q         <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            wbuf_q       <= 1'b0;
            start_q      <= 1'b0;
            start_buf_q  <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_buf_q     <= wr_buf_d;
            busy_q       <= busy_d;
            fht_active_q <= fht_active_d;
            fht_buf_q    <= fht_buf_d;
            q0_q         <= q0_d;
            q1_q         <= q1_d;
            q_n_q        <= q_n_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            wbuf_q       <= wbuf_d;
            start_q      <= start_d;
            start_buf_q  <= start_buf_d;
            ovf_q        <= ovf_d;
        end
    end
endmodule

// File: tb/tb_fht_frame_loader.sv
// tb_fht_frame_loader: table-driven, directed and randomized checks against a frame-level reference model
module tb_fht_frame_loader;
    localparam int N = 1024, BANKS = 4, D_BIT = 16, BS = N / BANKS, LB = 2;

    logic iCLK = 0, iRESET = 0, iARM = 0, iCONT = 0, iVALID = 0, iFHT_DONE = 0;
    logic [D_BIT-2:0] iDATA = '0;
    logic oREADY, oBUF, oSTART, oSTART_BUF, oOVF;
    logic [BANKS-1:0] oWE;
    logic [7:0] oADDR;
    logic [D_BIT-1:0] oDATA;
    logic [1:0] oBUSY;
    int errors = 0, checks = 0, starts = 0;

    fht_frame_loader #(.N(N), .BANKS(BANKS), .D_BIT(D_BIT)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iARM(iARM), .iCONT(iCONT), .iVALID(iVALID),
        .iDATA(iDATA), .oREADY(oREADY), .oWE(oWE), .oADDR(oADDR), .oDATA(oDATA),
        .oBUF(oBUF), .oSTART(oSTART), .oSTART_BUF(oSTART_BUF), .iFHT_DONE(iFHT_DONE),
        .oBUSY(oBUSY), .oOVF(oOVF)
    );

    always #5 iCLK = ~iCLK;

    // Reference model: frame position, buffer flags and a queue of completed frames
    bit m_fill, m_wb, m_act, m_fbuf, m_ovf;
    bit [1:0] m_busy;
    int m_k;
    int m_q[$];

    typedef struct {
        int k;
        logic [D_BIT-2:0] din;
        logic [BANKS-1:0] we;
        logic [7:0] addr;
        logic [D_BIT-1:0] dout;
    } vec_t;
    vec_t tbl[9];

    function automatic int bitrev(int b);
        int r = 0;
        for (int i = 0; i < LB; i++) r = r * 2 + ((b >> i) & 1);
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_fill = 0; m_wb = 0; m_act = 0; m_fbuf = 0; m_ovf = 0; m_busy = 0; m_k = 0;
        m_q.delete();
    endtask

    task automatic do_reset();
        iRESET = 1;
        #1;
        chk("rst_we", oWE, 0);
        chk("rst_ready", oREADY, 0);
        chk("rst_start", oSTART, 0);
        chk("rst_sbuf", oSTART_BUF, 0);
        chk("rst_busy", oBUSY, 0);
        chk("rst_ovf", oOVF, 0);
        chk("rst_addr", oADDR, 0);
        chk("rst_data", oDATA, 0);
        chk("rst_buf", oBUF, 0);
        model_reset();
        @(posedge iCLK);
        #1;
        iRESET = 0;
    endtask

    // One clock: advance the model with the current inputs, then compare every output
    task automatic cyc();
        bit ready, acc, e_start, e_sbuf, e_buf;
        int e_we, e_addr;
        logic [D_BIT-1:0] e_data;
        ready = m_fill && !m_busy[m_wb];
        acc = iVALID && ready;
        e_we = 0; e_addr = 0; e_data = 0; e_buf = 0; e_start = 0; e_sbuf = 0;
        if (!m_act && m_q.size() > 0) begin
            e_start = 1;
            e_sbuf = 1'(m_q.pop_front());
            m_act = 1;
            m_fbuf = e_sbuf;
        end else if (iFHT_DONE && m_act) begin
            m_busy[m_fbuf] = 0;
            m_act = 0;
        end
        if (m_fill && iVALID && !ready) m_ovf = 1;
        else if (iARM) m_ovf = 0;
        if (acc) begin
            e_we = 1 << bitrev(m_k / BS);
            e_addr = m_k % BS;
            e_data = D_BIT'($signed(iDATA));
            e_buf = m_wb;
            m_k++;
            if (m_k == N) begin
                m_busy[m_wb] = 1;
                m_q.push_back(int'(m_wb));
                m_wb = !m_wb;
                m_k = 0;
                m_fill = iCONT;
            end
        end else if (!m_fill && iARM) begin
            m_fill = 1;
            m_k = 0;
        end
        @(posedge iCLK);
        #1;
        chk("we", oWE, e_we);
        if (e_we != 0) begin
            chk("addr", oADDR, e_addr);
            chk("data", oDATA, e_data);
            chk("buf", oBUF, e_buf);
        end
        chk("start", oSTART, e_start);
        if (e_start) chk("start_buf", oSTART_BUF, e_sbuf);
        chk("ready", oREADY, m_fill && !m_busy[m_wb]);
        chk("busy", oBUSY, m_busy);
        chk("ovf", oOVF, m_ovf);
        if (oSTART) starts++;
    endtask

    initial begin
        int hit;
        tbl[0] = '{0,    15'h1234, 4'b0001, 8'd0,   16'h1234};
        tbl[1] = '{1,    15'h4000, 4'b0001, 8'd1,   16'hC000};
        tbl[2] = '{2,    15'h3FFF, 4'b0001, 8'd2,   16'h3FFF};
        tbl[3] = '{3,    15'h0000, 4'b0001, 8'd3,   16'h0000};
        tbl[4] = '{256,  15'h7FFF, 4'b0100, 8'd0,   16'hFFFF};
        tbl[5] = '{512,  15'h0001, 4'b0010, 8'd0,   16'h0001};
        tbl[6] = '{700,  15'h5555, 4'b0010, 8'd188, 16'hD555};
        tbl[7] = '{768,  15'h2AAA, 4'b1000, 8'd0,   16'h2AAA};
        tbl[8] = '{1023, 15'h4321, 4'b1000, 8'd255, 16'hC321};

        // Single frame, table-driven bank/address/sign-extension checks
        do_reset();
        chk("idle_ready", oREADY, 0);
        iCONT = 0; iARM = 1; cyc(); iARM = 0;
        chk("armed_ready", oREADY, 1);
        for (int k = 0; k < N; k++) begin
            iVALID = 1;
            iDATA = 15'(k);
            hit = -1;
            for (int t = 0; t < 9; t++) if (tbl[t].k == k) begin iDATA = tbl[t].din; hit = t; end
            cyc();
            if (hit >= 0) begin
                chk($sformatf("tbl_we_%0d", k), oWE, tbl[hit].we);
                chk($sformatf("tbl_addr_%0d", k), oADDR, tbl[hit].addr);
                chk($sformatf("tbl_data_%0d", k), oDATA, tbl[hit].dout);
            end
        end
        iVALID = 0; cyc();
        chk("s1_start", oSTART, 1);
        chk("s1_start_buf", oSTART_BUF, 0);
        chk("s1_ready", oREADY, 0);
        chk("s1_busy", oBUSY, 2'b01);
        iFHT_DONE = 1; cyc(); iFHT_DONE = 0;
        chk("s1_done_busy", oBUSY, 2'b00);

        // Continuous mode, both buffers fill, overflow and release
        do_reset();
        iCONT = 1; iARM = 1; cyc(); iARM = 0;
        starts = 0;
        for (int k = 0; k < 2 * N; k++) begin iVALID = 1; iDATA = 15'($urandom); cyc(); end
        iVALID = 0; cyc(); cyc();
        chk("s2_starts", starts, 1);
        chk("s2_busy", oBUSY, 2'b11);
        chk("s2_ready", oREADY, 0);
        iVALID = 1; cyc();
        chk("s2_ovf", oOVF, 1);
        iARM = 1; cyc();
        chk("s2_ovf_setwins", oOVF, 1);
        iVALID = 0; cyc(); iARM = 0;
        chk("s2_ovf_clear", oOVF, 0);
        iFHT_DONE = 1; cyc(); iFHT_DONE = 0;
        chk("s2_done_busy", oBUSY, 2'b10);
        chk("s2_done_ready", oREADY, 1);
        cyc();
        chk("s2_start2", oSTART, 1);
        chk("s2_start2_buf", oSTART_BUF, 1);

        // Reset in the middle of a frame
        do_reset();
        iCONT = 1; iARM = 1; cyc(); iARM = 0;
        for (int k = 0; k < 300; k++) begin iVALID = 1; iDATA = 15'(k); cyc(); end
        chk("mid_we_live", oWE != 0, 1);
        do_reset();
        chk("mid_ready", oREADY, 0);
        iVALID = 1; cyc(); cyc();
        chk("mid_nowrite", oWE, 0);
        iVALID = 0;

        // FHT done coincident with the last sample of buffer 1
        do_reset();
        iCONT = 1; iARM = 1; cyc(); iARM = 0;
        for (int k = 0; k < 2 * N - 1; k++) begin iVALID = 1; iDATA = 15'($urandom); cyc(); end
        iFHT_DONE = 1; cyc(); iFHT_DONE = 0;
        chk("s3_busy", oBUSY, 2'b10);
        cyc();
        chk("s3_start", oSTART, 1);
        chk("s3_start_buf", oSTART_BUF, 1);
        for (int k = 0; k < 100; k++) begin iDATA = 15'($urandom); cyc(); end
        chk("s3_ovf", oOVF, 0);
        chk("s3_ready", oREADY, 1);
        iVALID = 0;

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            if (i == 3000) do_reset();
            iARM = ($urandom % 50) == 0;
            iCONT = ($urandom % 4) != 0;
            iVALID = ($urandom % 5) != 0;
            iDATA = 15'($urandom);
            iFHT_DONE = ($urandom % 300) == 0;
            cyc();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
